// File: rtl/bp_cfg_boot_sequencer.sv
// Boot-time configuration sequencer: freezes each core, programs ID/cache/CCE modes,
// streams CCE microcode from a ROM, then unfreezes all cores once every write is acked.
module bp_cfg_boot_sequencer #(
  parameter int num_core_p        = 1,
  parameter int cfg_addr_width_p  = 20,
  parameter int cfg_data_width_p  = 64,
  parameter int cce_pc_width_p    = 8,
  parameter int max_outstanding_p = 4,
  parameter int skip_ucode_p      = 0,
  localparam int core_width_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1,
  localparam int credit_width_lp  = $clog2(max_outstanding_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  output logic [cce_pc_width_p-1:0]   ucode_addr_o,
  input  logic [cfg_data_width_p-1:0] ucode_data_i,
  output logic                        cfg_v_o,
  input  logic                        cfg_ready_i,
  output logic [core_width_lp-1:0]    cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ack_v_i,
  output logic                        done_o
);

  typedef enum logic [3:0] {
    e_reset,
    e_freeze,
    e_core_id,
    e_icache,
    e_dcache,
    e_cce_uncached,
    e_ucode,
    e_cce_normal,
    e_drain,
    e_unfreeze,
    e_drain2,
    e_done
  } state_e;

  localparam logic [cfg_addr_width_p-1:0] freeze_addr_lp      = cfg_addr_width_p'(32'h00008);
  localparam logic [cfg_addr_width_p-1:0] core_id_addr_lp     = cfg_addr_width_p'(32'h00010);
  localparam logic [cfg_addr_width_p-1:0] icache_mode_addr_lp = cfg_addr_width_p'(32'h00018);
  localparam logic [cfg_addr_width_p-1:0] dcache_mode_addr_lp = cfg_addr_width_p'(32'h00020);
  localparam logic [cfg_addr_width_p-1:0] cce_mode_addr_lp    = cfg_addr_width_p'(32'h00028);
  localparam logic [cfg_addr_width_p-1:0] ucode_base_addr_lp  = cfg_addr_width_p'(32'h08000);

  localparam logic [core_width_lp-1:0]   last_core_lp  = core_width_lp'(num_core_p - 1);
  localparam logic [credit_width_lp-1:0] max_credit_lp = credit_width_lp'(max_outstanding_p);

  state_e                        state_r, state_n;
  logic [core_width_lp-1:0]      core_r, core_n;
  logic [cce_pc_width_p-1:0]     idx_r, idx_n;
  logic [credit_width_lp-1:0]    credits_r, credits_n;
  logic [cfg_data_width_p-1:0]   data_r;
  logic                          cmd_v_n;
  logic [cfg_addr_width_p-1:0]   addr_n;
  logic [cfg_data_width_p-1:0]   data_n;
  logic                          xfer;
  logic                          next_core;
  logic                          last_core;

  // Saturating credit update: an ack with nothing outstanding is dropped.
  function automatic logic [credit_width_lp-1:0] credit_next(
    input logic [credit_width_lp-1:0] c,
    input logic                       inc,
    input logic                       dec
  );
    logic dec_ok;
    dec_ok = dec && (c != '0);
    case ({inc, dec_ok})
      2'b10:   return c + credit_width_lp'(1);
      2'b01:   return c - credit_width_lp'(1);
      default: return c;
    endcase
  endfunction

  assign xfer      = cfg_v_o & cfg_ready_i;
  assign last_core = (core_r == last_core_lp);
  assign credits_n = credit_next(credits_r, xfer, cfg_ack_v_i);

  always_comb begin
    state_n   = state_r;
    core_n    = core_r;
    idx_n     = idx_r;
    next_core = 1'b0;
    case (state_r)
      e_reset:   state_n = e_freeze;
      e_freeze:  if (xfer) state_n = e_core_id;
      e_core_id: if (xfer) state_n = e_icache;
      e_icache:  if (xfer) state_n = e_dcache;
      e_dcache:  if (xfer) state_n = e_cce_uncached;
      e_cce_uncached: begin
        if (xfer) begin
          if (skip_ucode_p != 0) next_core = 1'b1;
          else                   state_n   = e_ucode;
        end
      end
      e_ucode: begin
        if (xfer) begin
          idx_n = idx_r + cce_pc_width_p'(1);
          if (&idx_r) state_n = e_cce_normal;
        end
      end
      e_cce_normal: if (xfer) next_core = 1'b1;
      e_drain:      if (credits_r == '0) state_n = e_unfreeze;
      e_unfreeze: begin
        if (xfer) begin
          if (last_core) begin
            state_n = e_drain2;
            core_n  = '0;
          end else begin
            core_n  = core_r + core_width_lp'(1);
          end
        end
      end
      e_drain2: if (credits_r == '0) state_n = e_done;
      e_done:   state_n = e_done;
      default:  state_n = e_reset;
    endcase

    // The core counter is reused by the unfreeze pass, so it restarts at 0 on drain.
    if (next_core) begin
      if (last_core) begin
        state_n = e_drain;
        core_n  = '0;
      end else begin
        state_n = e_freeze;
        core_n  = core_r + core_width_lp'(1);
      end
    end
  end

  // Command fields are decoded from the next state so the outputs can be registered.
  always_comb begin
    cmd_v_n = 1'b1;
    addr_n  = '0;
    data_n  = '0;
    case (state_n)
      e_freeze: begin
        addr_n = freeze_addr_lp;
        data_n = cfg_data_width_p'(1);
      end
      e_core_id: begin
        addr_n = core_id_addr_lp;
        data_n = cfg_data_width_p'(core_n);
      end
      e_icache: begin
        addr_n = icache_mode_addr_lp;
        data_n = cfg_data_width_p'(1);
      end
      e_dcache: begin
        addr_n = dcache_mode_addr_lp;
        data_n = cfg_data_width_p'(1);
      end
      e_cce_uncached: begin
        addr_n = cce_mode_addr_lp;
        data_n = '0;
      end
      e_ucode: begin
        addr_n = ucode_base_addr_lp + cfg_addr_width_p'(idx_n);
        data_n = '0;
      end
      e_cce_normal: begin
        addr_n = cce_mode_addr_lp;
        data_n = cfg_data_width_p'(1);
      end
      e_unfreeze: begin
        addr_n = freeze_addr_lp;
        data_n = '0;
      end
      default: cmd_v_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_reset;
      core_r     <= '0;
      idx_r      <= '0;
      credits_r  <= '0;
      cfg_v_o    <= 1'b0;
      cfg_core_o <= '0;
      cfg_addr_o <= '0;
      data_r     <= '0;
      done_o     <= 1'b0;
    end else begin
      state_r    <= state_n;
      core_r     <= core_n;
      idx_r      <= idx_n;
      credits_r  <= credits_n;
      cfg_v_o    <= cmd_v_n && (credits_n != max_credit_lp);
      cfg_core_o <= core_n;
      cfg_addr_o <= addr_n;
      data_r     <= data_n;
      done_o     <= (state_n == e_done);
    end
  end

  // Microcode words come straight from the combinational ROM at the current index.
  assign ucode_addr_o = idx_r;
  assign cfg_data_o   = (state_r == e_ucode) ? ucode_data_i : data_r;

endmodule
